// File: rtl/fan_ctrl_pkg.sv
// Shared types and constants for the board fan controller.
package fan_ctrl_pkg;
  localparam int FanLevelW = 8;
  localparam int FanSwMult = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KICK = 2'd1,
    RAMP = 2'd2,
    HOLD = 2'd3
  } fan_state_e;

  // 0..15 maps exactly onto 0..255.
  function automatic logic [FanLevelW-1:0] sw_to_target(input logic [3:0] sw);
    return {4'd0, sw} * FanLevelW'(FanSwMult);
  endfunction
endpackage

// File: rtl/fan_pwm_gen.sv
// PWM generator: threshold latched only at period start, so duty never changes mid-period.
module fan_pwm_gen
  import fan_ctrl_pkg::*;
#(
  parameter int PwmPeriod = 2000
) (
  input  logic                 soc_clk,
  input  logic                 rst_n,
  input  logic [FanLevelW-1:0] level,
  output logic                 pwm
);
  localparam int CW = $clog2(PwmPeriod);
  localparam int TW = $clog2(PwmPeriod + 1);
  localparam int PW = FanLevelW + TW;

  logic [CW-1:0] cnt;
  logic [TW-1:0] thr, thr_new, thr_eff;
  logic [PW-1:0] prod;
  logic          at_start;

  assign at_start = (cnt == '0);

  // Full level maps to the whole period so the output never dips for a cycle.
  always_comb begin
    prod = PW'(level) * PW'(PwmPeriod);
    if (level == '1) thr_new = TW'(PwmPeriod);
    else             thr_new = TW'(prod >> FanLevelW);
    thr_eff = at_start ? thr_new : thr;
  end

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      thr <= '0;
      pwm <= 1'b0;
    end else begin
      cnt <= (cnt == CW'(PwmPeriod - 1)) ? '0 : cnt + 1'b1;
      if (at_start) thr <= thr_new;
      pwm <= (TW'(cnt) < thr_eff);
    end
  end
endmodule

// File: rtl/fan_pwm_ramp_ctrl.sv
// Fan controller: switch sync/debounce, optional kick-start, 1-LSB duty ramp, PWM drive.
// Define FAN_KICKSTART_EN to spin a stopped fan at full speed before ramping.
module fan_pwm_ramp_ctrl
  import fan_ctrl_pkg::*;
#(
  parameter int PwmPeriod      = 2000,
  parameter int RampCycles     = 50000,
  parameter int DebounceCycles = 500000,
  parameter int KickCycles     = 25000000
) (
  input  logic                 soc_clk,
  input  logic                 rst_n,
  input  logic [3:0]           fan_sw_i,
  output logic                 fan_pwm_o,
  output logic [FanLevelW-1:0] level_o,
  output logic [1:0]           state_o,
  output logic                 settled_o
);
  localparam int DW = $clog2(DebounceCycles + 1);
  localparam int RW = $clog2(RampCycles + 1);

  logic [3:0]           sync1, sync2, cand, sw_q;
  logic [DW-1:0]        db_cnt;
  logic [FanLevelW-1:0] target, level, level_n, step;
  logic [RW-1:0]        ramp_cnt, ramp_n;
  fan_state_e           state, state_n;

  // db_cnt counts cycles the candidate has been seen, including its first.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      db_cnt <= '0;
      sw_q   <= '0;
    end else begin
      sync1 <= fan_sw_i;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand   <= sync2;
        db_cnt <= DW'(1);
        if (DebounceCycles == 1) sw_q <= sync2;
      end else if (db_cnt >= DW'(DebounceCycles - 1)) begin
        sw_q <= cand;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign target = sw_to_target(sw_q);

`ifdef FAN_KICKSTART_EN
  localparam int KW = $clog2(KickCycles + 1);
  logic [KW-1:0] kick_cnt, kick_n;

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) kick_cnt <= '0;
    else        kick_cnt <= kick_n;
  end
`endif

  always_comb begin
    state_n = state;
    level_n = level;
    ramp_n  = ramp_cnt;
    step    = (target > level) ? level + 1'b1 : level - 1'b1;
`ifdef FAN_KICKSTART_EN
    kick_n  = kick_cnt;
`endif
    case (state)
      IDLE: begin
        level_n = '0;
        if (target != '0) begin
`ifdef FAN_KICKSTART_EN
          state_n = KICK;
          level_n = '1;
          kick_n  = '0;
`else
          state_n = RAMP;
          ramp_n  = '0;
`endif
        end
      end
`ifdef FAN_KICKSTART_EN
      KICK: begin
        if (kick_cnt == KW'(KickCycles - 1)) begin
          state_n = RAMP;
          ramp_n  = '0;
        end else begin
          kick_n = kick_cnt + 1'b1;
        end
      end
`endif
      RAMP: begin
        // A step landing on target leaves RAMP in the same cycle.
        if (level == target) begin
          state_n = (target == '0) ? IDLE : HOLD;
        end else if (ramp_cnt == RW'(RampCycles - 1)) begin
          ramp_n  = '0;
          level_n = step;
          if (step == target) state_n = (target == '0) ? IDLE : HOLD;
        end else begin
          ramp_n = ramp_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (target != level) begin
          state_n = RAMP;
          ramp_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      level    <= '0;
      ramp_cnt <= '0;
    end else begin
      state    <= state_n;
      level    <= level_n;
      ramp_cnt <= ramp_n;
    end
  end

  fan_pwm_gen #(.PwmPeriod(PwmPeriod)) u_pwm (
    .soc_clk (soc_clk),
    .rst_n   (rst_n),
    .level   (level),
    .pwm     (fan_pwm_o)
  );

  assign level_o   = level;
  assign state_o   = state;
  assign settled_o = (level == target) && (state == HOLD || state == IDLE);
endmodule

// File: tb/tb_fan_pwm_ramp_ctrl.sv
// Directed table-driven bench for fan_pwm_ramp_ctrl; expectations follow FAN_KICKSTART_EN.
module tb_fan_pwm_ramp_ctrl;
  localparam int S_IDLE = 0, S_KICK = 1, S_RAMP = 2, S_HOLD = 3;

  logic       soc_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [3:0] fan_sw  = 4'd15;
  logic       fan_pwm;
  logic [7:0] level;
  logic [1:0] state;
  logic       settled;

  // Each record: drive sw, wait wt negedges (time counted from the drive when sw changes),
  // then check state/level/settled; highs >= 0 also counts PWM-high cycles over 16 cycles.
  typedef struct {
    logic [3:0] sw;
    int wt;
    int st;
    int lvl;
    int set;
    int highs;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0, failures = 0;
  bit   saw_kick = 1'b0;

  fan_pwm_ramp_ctrl #(
    .PwmPeriod(16), .RampCycles(4), .DebounceCycles(8), .KickCycles(64)
  ) dut (
    .soc_clk   (soc_clk),
    .rst_n     (rst_n),
    .fan_sw_i  (fan_sw),
    .fan_pwm_o (fan_pwm),
    .level_o   (level),
    .state_o   (state),
    .settled_o (settled)
  );

  always #5 soc_clk = ~soc_clk;

  always @(negedge soc_clk) if (rst_n && state == 2'd1) saw_kick <= 1'b1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] sw, input int wt, input int st, input int lvl,
                     input int set, input int highs);
    vec_t v;
    v.sw = sw; v.wt = wt; v.st = st; v.lvl = lvl; v.set = set; v.highs = highs;
    vecs.push_back(v);
  endtask

  task automatic count_highs(output int h);
    h = 0;
    repeat (16) begin
      @(negedge soc_clk);
      h += int'(fan_pwm);
    end
  endtask

  initial begin
    int bounce_bad, h;

`ifdef FAN_KICKSTART_EN
    add(15, 10, S_IDLE,   0, 0, -1);
    add(15,  1, S_KICK, 255, 0, -1);
    add(15, 20, S_KICK, 255, 0, 16);
    add(15, 27, S_KICK, 255, 0, -1);
    add(15,  1, S_RAMP, 255, 0, -1);
    add(15,  1, S_HOLD, 255, 1, -1);
    add( 8, 10, S_HOLD, 255, 0, -1);
    add( 8,  1, S_RAMP, 255, 0, -1);
    add( 8,  4, S_RAMP, 254, 0, -1);
    add( 8, 471, S_RAMP, 137, 0, -1);
    add( 8,  1, S_HOLD, 136, 1, -1);
    add( 8, 16, S_HOLD, 136, 1,  8);
`else
    add( 1, 10, S_IDLE,   0, 0, -1);
    add( 1,  1, S_RAMP,   0, 0, -1);
    add( 1,  4, S_RAMP,   1, 0, -1);
    add( 1, 63, S_RAMP,  16, 0, -1);
    add( 1,  1, S_HOLD,  17, 1, -1);
    add( 1, 16, S_HOLD,  17, 1,  1);
    add( 8, 10, S_HOLD,  17, 0, -1);
    add( 8,  1, S_RAMP,  17, 0, -1);
    add( 8, 475, S_RAMP, 135, 0, -1);
    add( 8,  1, S_HOLD, 136, 1, -1);
    add( 8, 16, S_HOLD, 136, 1,  8);
`endif
    add( 1, 10, S_HOLD, 136, 0, -1);
    add( 1,  1, S_RAMP, 136, 0, -1);
    add( 1, 475, S_RAMP, 18, 0, -1);
    add( 1,  1, S_HOLD,  17, 1, -1);
    add( 1, 16, S_HOLD,  17, 1,  1);
    add( 0, 11, S_RAMP,  17, 0, -1);
    add( 0, 67, S_RAMP,   1, 0, -1);
    add( 0,  1, S_IDLE,   0, 1, -1);
    add( 0, 16, S_IDLE,   0, 1,  0);

    // Reset held with switches at full: outputs stay at reset values.
    for (int i = 0; i < 4; i++) begin
      repeat (25) @(negedge soc_clk);
      chk($sformatf("rst%0d_pwm", i), int'(fan_pwm), 0);
      chk($sformatf("rst%0d_level", i), int'(level), 0);
      chk($sformatf("rst%0d_state", i), int'(state), 0);
      chk($sformatf("rst%0d_settled", i), int'(settled), 1);
    end
    fan_sw = 4'd0;
    @(negedge soc_clk);
    rst_n = 1'b1;

    // Bounce with 5-cycle runs never gets past the 8-cycle debounce.
    bounce_bad = 0;
    for (int i = 0; i < 20; i++) begin
      fan_sw = (i % 2 == 0) ? 4'd15 : 4'd0;
      repeat (5) begin
        @(negedge soc_clk);
        if (state != 2'd0 || level != 8'd0) bounce_bad++;
      end
    end
    fan_sw = 4'd0;
    repeat (12) @(negedge soc_clk);
    chk("bounce_bad_cycles", bounce_bad, 0);
    chk("bounce_state", int'(state), S_IDLE);
    chk("bounce_level", int'(level), 0);

    foreach (vecs[i]) begin
      fan_sw = vecs[i].sw;
      repeat (vecs[i].wt) @(negedge soc_clk);
      chk($sformatf("v%0d_state", i), int'(state), vecs[i].st);
      chk($sformatf("v%0d_level", i), int'(level), vecs[i].lvl);
      chk($sformatf("v%0d_settled", i), int'(settled), vecs[i].set);
      if (vecs[i].highs >= 0) begin
        count_highs(h);
        chk($sformatf("v%0d_pwm_highs", i), h, vecs[i].highs);
      end
    end

    // Asynchronous reset mid-operation, then a fresh debounce from zero.
    fan_sw = 4'd8;
    repeat (40) @(negedge soc_clk);
    chk("pre_rst_level_nonzero", int'(level != 8'd0 || state != 2'd0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pwm", int'(fan_pwm), 0);
    chk("arst_level", int'(level), 0);
    chk("arst_state", int'(state), 0);
    chk("arst_settled", int'(settled), 1);
    @(negedge soc_clk);
    rst_n = 1'b1;
    repeat (5) @(negedge soc_clk);
    chk("post_rst_state", int'(state), S_IDLE);
    chk("post_rst_level", int'(level), 0);
    repeat (6) @(negedge soc_clk);
`ifdef FAN_KICKSTART_EN
    chk("post_rst_react", int'(state), S_KICK);
    chk("kick_seen", int'(saw_kick), 1);
`else
    chk("post_rst_react", int'(state), S_RAMP);
    chk("kick_never_seen", int'(saw_kick), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
